// File: rtl/hiscore_ram_arbiter.sv
// Two-port arbiter for the core's single hiscore RAM port. It halts the CPU through
// pause_out, lets the bus settle, performs one byte access and pulses the requester's ack.
module hiscore_ram_arbiter #(
    parameter int AW     = 16,
    parameter int SETTLE = 4,
    parameter int RD_LAT = 2,
    parameter int HOLD   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          user_pause,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [7:0]    wdata0,
    input  logic [7:0]    wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [7:0]    rdata,
    output logic [AW-1:0] hs_addr,
    output logic [7:0]    hs_din,
    output logic          hs_we,
    input  logic [7:0]    hs_dout,
    output logic          pause_out,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_GRANT,
        S_RD_WAIT,
        S_DONE,
        S_HOLD
    } state_e;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [7:0] RD_LD     = 8'(RD_LAT - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          rr_q, rr_d;
    logic          sel_q, sel_d;
    logic          we_sel_q, we_sel_d;
    logic [AW-1:0] hs_addr_q, hs_addr_d;
    logic [7:0]    hs_din_q, hs_din_d;
    logic          hs_we_q, hs_we_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          pick1;
    logic          take;

    // On a tie the port opposite the round-robin pointer wins.
    always_comb begin
        pick1 = req1 ? (!req0 || !rr_q) : (!req0 && !rr_q);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            rr_q      <= 1'b1;
            sel_q     <= 1'b0;
            we_sel_q  <= 1'b0;
            hs_addr_q <= '0;
            hs_din_q  <= 8'd0;
            hs_we_q   <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            rdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            sel_q     <= sel_d;
            we_sel_q  <= we_sel_d;
            hs_addr_q <= hs_addr_d;
            hs_din_q  <= hs_din_d;
            hs_we_q   <= hs_we_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        sel_d     = sel_q;
        we_sel_d  = we_sel_q;
        hs_addr_d = hs_addr_q;
        hs_din_d  = hs_din_q;
        hs_we_d   = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        rdata_d   = rdata_q;
        take      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 8'd0) take = 1'b1;
                else               cnt_d = cnt_q - 8'd1;
            end
            S_GRANT: begin
                if (we_sel_q) begin
                    state_d = S_DONE;
                    ack0_d  = !sel_q;
                    ack1_d  = sel_q;
                end else begin
                    state_d = S_RD_WAIT;
                    cnt_d   = RD_LD;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_DONE;
                    rdata_d = hs_dout;
                    ack0_d  = !sel_q;
                    ack1_d  = sel_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                if (HOLD == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (req0 || req1)       take    = 1'b1;
                else if (cnt_q == 8'd0) state_d = S_IDLE;
                else                    cnt_d   = cnt_q - 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        // The grant is registered on entry so the access is presented during GRANT itself.
        if (take) begin
            state_d   = S_GRANT;
            sel_d     = pick1;
            rr_d      = pick1;
            we_sel_d  = pick1 ? we1 : we0;
            hs_addr_d = pick1 ? addr1 : addr0;
            hs_din_d  = pick1 ? wdata1 : wdata0;
            hs_we_d   = pick1 ? we1 : we0;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        pause_out = user_pause || (state_q != S_IDLE);
        ack0      = ack0_q;
        ack1      = ack1_q;
        rdata     = rdata_q;
        hs_addr   = hs_addr_q;
        hs_din    = hs_din_q;
        hs_we     = hs_we_q;
    end

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Directed bench for hiscore_ram_arbiter with default parameters; cycle 0 is the
// first cycle a request is visible while the arbiter is idle.
module tb_hiscore_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        user_pause;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ack0, ack1;
    logic [7:0]  rdata;
    logic [15:0] hs_addr;
    logic [7:0]  hs_din;
    logic        hs_we;
    logic [7:0]  hs_dout;
    logic        pause_out, busy;

    int checks = 0;
    int errors = 0;

    hiscore_ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .user_pause (user_pause),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata      (rdata),
        .hs_addr    (hs_addr),
        .hs_din     (hs_din),
        .hs_we      (hs_we),
        .hs_dout    (hs_dout),
        .pause_out  (pause_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // RAM model: data = addr[7:0] ^ 8'h2C, two clocks after the address is presented.
    logic [7:0] dout_d1 = 8'd0;
    logic [7:0] dout_d2 = 8'd0;
    always @(posedge clk) begin
        dout_d1 <= hs_addr[7:0] ^ 8'h2C;
        dout_d2 <= dout_d1;
    end
    assign hs_dout = dout_d2;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        user_pause = 1'b0;
        idle_inputs();
        repeat (3) step();
        checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b%b exp=00", ack0, ack1); end
        checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got=%h exp=00", rdata); end
        checks++; if (hs_addr !== 16'h0 || hs_din !== 8'h0) begin errors++; $display("FAIL rst_bus got=%h/%h exp=0000/00", hs_addr, hs_din); end
        checks++; if (hs_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", hs_we); end
        checks++; if (pause_out !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_pause_busy got=%b%b exp=00", pause_out, busy); end
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_write();
        logic e;
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) step();
            if (c == 0) begin req0 = 1'b1; we0 = 1'b1; addr0 = 16'h1234; wdata0 = 8'hA5; end
            if (c == 7) req0 = 1'b0;
            #1;
            e = (c >= 1 && c <= 22);
            checks++; if (pause_out !== e) begin errors++; $display("FAIL wr_pause c=%0d got=%b exp=%b", c, pause_out, e); end
            checks++; if (busy !== e) begin errors++; $display("FAIL wr_busy c=%0d got=%b exp=%b", c, busy, e); end
            e = (c == 5);
            checks++; if (hs_we !== e) begin errors++; $display("FAIL wr_we c=%0d got=%b exp=%b", c, hs_we, e); end
            e = (c == 6);
            checks++; if (ack0 !== e || ack1 !== 1'b0) begin errors++; $display("FAIL wr_ack c=%0d got=%b%b exp=0%b", c, ack1, ack0, e); end
            if (c == 5) begin
                checks++; if (hs_addr !== 16'h1234 || hs_din !== 8'hA5) begin errors++; $display("FAIL wr_bus got=%h/%h exp=1234/a5", hs_addr, hs_din); end
            end
        end
    endtask

    task automatic test_read();
        logic e;
        for (int c = 0; c <= 26; c++) begin
            if (c > 0) step();
            if (c == 0) begin req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0010; end
            if (c == 9) req1 = 1'b0;
            #1;
            e = (c >= 1 && c <= 24);
            checks++; if (pause_out !== e) begin errors++; $display("FAIL rd_pause c=%0d got=%b exp=%b", c, pause_out, e); end
            checks++; if (hs_we !== 1'b0) begin errors++; $display("FAIL rd_we c=%0d got=%b exp=0", c, hs_we); end
            e = (c == 8);
            checks++; if (ack1 !== e || ack0 !== 1'b0) begin errors++; $display("FAIL rd_ack c=%0d got=%b%b exp=%b0", c, ack1, ack0, e); end
            checks++;
            if (rdata !== ((c >= 8) ? 8'h3C : 8'h00)) begin
                errors++; $display("FAIL rd_data c=%0d got=%h exp=%h", c, rdata, (c >= 8) ? 8'h3C : 8'h00);
            end
            if (c >= 5 && c <= 7) begin
                checks++; if (hs_addr !== 16'h0010) begin errors++; $display("FAIL rd_addr c=%0d got=%h exp=0010", c, hs_addr); end
            end
        end
    endtask

    task automatic test_fairness();
        logic e;
        for (int c = 0; c <= 37; c++) begin
            if (c > 0) step();
            if (c == 0) begin
                req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0200; wdata0 = 8'h5A;
                req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0055;
            end
            if (c == 20) begin req0 = 1'b0; req1 = 1'b0; end
            #1;
            e = (c >= 1 && c <= 35);
            checks++; if (pause_out !== e) begin errors++; $display("FAIL fair_pause c=%0d got=%b exp=%b", c, pause_out, e); end
            e = (c == 6 || c == 14);
            checks++; if (ack0 !== e) begin errors++; $display("FAIL fair_ack0 c=%0d got=%b exp=%b", c, ack0, e); end
            e = (c == 11 || c == 19);
            checks++; if (ack1 !== e) begin errors++; $display("FAIL fair_ack1 c=%0d got=%b exp=%b", c, ack1, e); end
            e = (c == 5 || c == 13);
            checks++; if (hs_we !== e) begin errors++; $display("FAIL fair_we c=%0d got=%b exp=%b", c, hs_we, e); end
            if (c == 8 || c == 16) begin
                checks++; if (hs_addr !== 16'h0055) begin errors++; $display("FAIL fair_addr1 c=%0d got=%h exp=0055", c, hs_addr); end
            end
            if (c == 11 || c == 37) begin
                checks++; if (rdata !== 8'h79) begin errors++; $display("FAIL fair_rdata c=%0d got=%h exp=79", c, rdata); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        for (int c = 0; c <= 31; c++) begin
            if (c > 0) step();
            if (c == 0) begin req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0300; wdata0 = 8'h11; end
            if (c == 7) req0 = 1'b0;
            if (c == 9) begin req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0021; end
            if (c == 14) req0 = 1'b0;
            #1;
            e = (c >= 1 && c <= 29);
            checks++; if (pause_out !== e) begin errors++; $display("FAIL b2b_pause c=%0d got=%b exp=%b", c, pause_out, e); end
            e = (c == 6 || c == 13);
            checks++; if (ack0 !== e) begin errors++; $display("FAIL b2b_ack0 c=%0d got=%b exp=%b", c, ack0, e); end
            e = (c == 5);
            checks++; if (hs_we !== e) begin errors++; $display("FAIL b2b_we c=%0d got=%b exp=%b", c, hs_we, e); end
            if (c == 10) begin
                checks++; if (hs_addr !== 16'h0021) begin errors++; $display("FAIL b2b_addr got=%h exp=0021", hs_addr); end
            end
            if (c == 13) begin
                checks++; if (rdata !== 8'h0D) begin errors++; $display("FAIL b2b_rdata got=%h exp=0d", rdata); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic e;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) step();
            if (c == 0) begin req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0044; end
            if (c == 6) begin reset = 1'b1; req1 = 1'b0; end
            if (c == 7) reset = 1'b0;
            #1;
            if (c == 6) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
            end
            if (c >= 7) begin
                checks++; if (busy !== 1'b0 || pause_out !== 1'b0) begin errors++; $display("FAIL mid_idle c=%0d got=%b%b exp=00", c, busy, pause_out); end
                checks++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || hs_we !== 1'b0) begin errors++; $display("FAIL mid_strobes c=%0d got=%b%b%b exp=000", c, ack0, ack1, hs_we); end
            end
            if (c == 7) begin
                checks++; if (rdata !== 8'h00 || hs_addr !== 16'h0) begin errors++; $display("FAIL mid_regs got=%h/%h exp=00/0000", rdata, hs_addr); end
            end
        end
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) step();
            if (c == 0) begin req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0500; wdata0 = 8'h66; end
            if (c == 7) req0 = 1'b0;
            #1;
            e = (c == 6);
            checks++; if (ack0 !== e) begin errors++; $display("FAIL mid_after_ack c=%0d got=%b exp=%b", c, ack0, e); end
            e = (c >= 1 && c <= 22);
            checks++; if (busy !== e) begin errors++; $display("FAIL mid_after_busy c=%0d got=%b exp=%b", c, busy, e); end
        end
    endtask

    task automatic test_user_pause();
        logic e;
        user_pause = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (pause_out !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL up_idle c=%0d got=%b%b exp=10", c, pause_out, busy); end
        end
        for (int c = 0; c <= 24; c++) begin
            if (c > 0) step();
            if (c == 0) begin req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0400; wdata0 = 8'h77; end
            if (c == 7) req0 = 1'b0;
            #1;
            checks++; if (pause_out !== 1'b1) begin errors++; $display("FAIL up_pause c=%0d got=%b exp=1", c, pause_out); end
            e = (c == 5);
            checks++; if (hs_we !== e) begin errors++; $display("FAIL up_we c=%0d got=%b exp=%b", c, hs_we, e); end
            e = (c == 6);
            checks++; if (ack0 !== e) begin errors++; $display("FAIL up_ack c=%0d got=%b exp=%b", c, ack0, e); end
            e = (c >= 1 && c <= 22);
            checks++; if (busy !== e) begin errors++; $display("FAIL up_busy c=%0d got=%b exp=%b", c, busy, e); end
        end
        user_pause = 1'b0;
        #1;
        checks++; if (pause_out !== 1'b0) begin errors++; $display("FAIL up_release got=%b exp=0", pause_out); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fairness();
        test_back_to_back();
        test_reset_mid_read();
        test_user_pause();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
